// File: rtl/cp0_reg.sv
// cp0_reg: CP0 register file with exception capture and Count/Compare timer (optional CP0_TIMER_EN)
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE = 32'h0048_0102
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_cp0_reg_we,
    input  logic [4:0]  wb_cp0_reg_write_addr,
    input  logic [31:0] wb_cp0_reg_data,
    input  logic [4:0]  cp0_reg_read_addr,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    output logic [31:0] cp0_reg_data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);
    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_STATUS  = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;
    localparam logic [4:0]  ADDR_CONFIG  = 5'd16;
    localparam logic [31:0] STATUS_RST   = 32'h1000_0000;
    localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;
    // Cause bits software may write: IV, WP, IP[1:0]
    localparam logic [31:0] CAUSE_WMASK  = 32'h00C0_0300;

    logic [31:0] count_q, count_d, compare_q, compare_d, status_q, status_d;
    logic [31:0] cause_q, cause_d, epc_q, epc_d;
    logic        timer_q, timer_d;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic        exc, eret;
    logic [4:0]  exc_code;
    logic        bypass;

    assign wr_count   = wb_cp0_reg_we && wb_cp0_reg_write_addr == ADDR_COUNT;
    assign wr_compare = wb_cp0_reg_we && wb_cp0_reg_write_addr == ADDR_COMPARE;
    assign wr_status  = wb_cp0_reg_we && wb_cp0_reg_write_addr == ADDR_STATUS;
    assign wr_cause   = wb_cp0_reg_we && wb_cp0_reg_write_addr == ADDR_CAUSE;
    assign wr_epc     = wb_cp0_reg_we && wb_cp0_reg_write_addr == ADDR_EPC;
    assign exc  = excepttype_i inside {32'h1, 32'h8, 32'ha, 32'hd, 32'hc};
    assign eret = excepttype_i == 32'he;
    assign exc_code = excepttype_i == 32'h8 ? 5'd8  :
                      excepttype_i == 32'ha ? 5'd10 :
                      excepttype_i == 32'hd ? 5'd13 :
                      excepttype_i == 32'hc ? 5'd12 : 5'd0;

    // Next state: register write first, then exception/eret field overrides
    always_comb begin
        count_d   = wr_count   ? wb_cp0_reg_data : count_q + 32'd1;
        compare_d = wr_compare ? wb_cp0_reg_data : compare_q;
        status_d  = wr_status  ? wb_cp0_reg_data : status_q;
        epc_d     = wr_epc     ? wb_cp0_reg_data : epc_q;
        cause_d   = wr_cause   ? (cause_q & ~CAUSE_WMASK) | (wb_cp0_reg_data & CAUSE_WMASK) : cause_q;
        cause_d[15:10] = int_i;
        if (exc) begin
            if (!status_q[1]) begin
                epc_d      = current_inst_addr_i - (is_in_delayslot_i ? 32'd4 : 32'd0);
                cause_d[31] = is_in_delayslot_i;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code;
        end else if (eret) begin
            status_d[1] = 1'b0;
        end
`ifdef CP0_TIMER_EN
        timer_d = wr_compare ? 1'b0 : (compare_q != 32'd0 && count_q == compare_q) ? 1'b1 : timer_q;
`else
        timer_d = 1'b0;
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= STATUS_RST;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
            timer_q   <= timer_d;
        end
    end

    assign bypass = wb_cp0_reg_we && wb_cp0_reg_write_addr == cp0_reg_read_addr;

    // Combinational read port with write-back bypass
    always_comb begin
        cp0_reg_data_o = 32'd0;
        case (cp0_reg_read_addr)
            ADDR_COUNT:   cp0_reg_data_o = bypass ? wb_cp0_reg_data : count_q;
            ADDR_COMPARE: cp0_reg_data_o = bypass ? wb_cp0_reg_data : compare_q;
            ADDR_STATUS:  cp0_reg_data_o = bypass ? wb_cp0_reg_data : status_q;
            ADDR_CAUSE:   cp0_reg_data_o = bypass ? (cause_q & ~CAUSE_WMASK) | (wb_cp0_reg_data & CAUSE_WMASK) : cause_q;
            ADDR_EPC:     cp0_reg_data_o = bypass ? wb_cp0_reg_data : epc_q;
            ADDR_PRID:    cp0_reg_data_o = PRID_VALUE;
            ADDR_CONFIG:  cp0_reg_data_o = CONFIG_VALUE;
            default:      cp0_reg_data_o = 32'd0;
        endcase
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = CONFIG_VALUE;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = timer_q;
endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed scoreboard bench for cp0_reg
module tb_cp0_reg;
    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_cp0_reg_we;
    logic [4:0]  wb_cp0_reg_write_addr;
    logic [31:0] wb_cp0_reg_data;
    logic [4:0]  cp0_reg_read_addr;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] cp0_reg_data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

`ifdef CP0_TIMER_EN
    localparam logic [31:0] TIMER_ON = 32'd1;
`else
    localparam logic [31:0] TIMER_ON = 32'd0;
`endif

    cp0_reg dut (
        .clk(clk), .resetn(resetn),
        .wb_cp0_reg_we(wb_cp0_reg_we), .wb_cp0_reg_write_addr(wb_cp0_reg_write_addr),
        .wb_cp0_reg_data(wb_cp0_reg_data), .cp0_reg_read_addr(cp0_reg_read_addr),
        .int_i(int_i), .excepttype_i(excepttype_i), .current_inst_addr_i(current_inst_addr_i),
        .is_in_delayslot_i(is_in_delayslot_i), .cp0_reg_data_o(cp0_reg_data_o),
        .count_o(count_o), .compare_o(compare_o), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %h exp none", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s got %h exp %h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wb_cp0_reg_we = 1'b1;
        wb_cp0_reg_write_addr = a;
        wb_cp0_reg_data = d;
        step();
        wb_cp0_reg_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e);
        cp0_reg_read_addr = a;
        push(tag, e);
        #1;
        check(cp0_reg_data_o);
    endtask

    initial begin
        resetn = 1'b0;
        wb_cp0_reg_we = 1'b0;
        wb_cp0_reg_write_addr = 5'd0;
        wb_cp0_reg_data = 32'd0;
        cp0_reg_read_addr = 5'd0;
        int_i = 6'd0;
        excepttype_i = 32'd0;
        current_inst_addr_i = 32'd0;
        is_in_delayslot_i = 1'b0;
        #12;
        rd("rst_status", 5'd12, 32'h1000_0000);
        rd("rst_config", 5'd16, 32'h0000_8000);
        rd("rst_prid", 5'd15, 32'h0048_0102);
        push("rst_count", 32'd0); check(count_o);
        push("rst_timer", 32'd0); check({31'd0, timer_int_o});
        push("prid_o", 32'h0048_0102); check(prid_o);
        push("config_o", 32'h0000_8000); check(config_o);

        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (5) step();
        push("count_after5", 32'd5); check(count_o);

        wb_cp0_reg_we = 1'b1;
        wb_cp0_reg_write_addr = 5'd13;
        wb_cp0_reg_data = 32'hFFFF_FFFF;
        int_i = 6'b000001;
        rd("cause_bypass", 5'd13, 32'h00C0_0300);
        push("cause_written", 32'h00C0_0700);
        step();
        wb_cp0_reg_we = 1'b0;
        check(cause_o);
        rd("cause_read", 5'd13, 32'h00C0_0700);
        int_i = 6'd0;

        excepttype_i = 32'h8;
        current_inst_addr_i = 32'hBFC0_0100;
        is_in_delayslot_i = 1'b1;
        push("sys_epc", 32'hBFC0_00FC);
        push("sys_cause", 32'h80C0_0320);
        push("sys_status", 32'h1000_0002);
        step();
        check(epc_o); check(cause_o); check(status_o);

        excepttype_i = 32'ha;
        current_inst_addr_i = 32'h0000_1234;
        is_in_delayslot_i = 1'b0;
        push("exc2_epc", 32'hBFC0_00FC);
        push("exc2_cause", 32'h80C0_0328);
        step();
        check(epc_o); check(cause_o);

        excepttype_i = 32'he;
        push("eret_status", 32'h1000_0000);
        push("eret_cause", 32'h80C0_0328);
        step();
        check(status_o); check(cause_o);

        excepttype_i = 32'h5;
        push("unk_status", 32'h1000_0000);
        push("unk_epc", 32'hBFC0_00FC);
        push("unk_cause", 32'h80C0_0328);
        step();
        check(status_o); check(epc_o); check(cause_o);
        excepttype_i = 32'd0;

        wb_cp0_reg_we = 1'b1;
        wb_cp0_reg_write_addr = 5'd14;
        wb_cp0_reg_data = 32'hDEAD_BEEF;
        rd("epc_bypass", 5'd14, 32'hDEAD_BEEF);
        push("epc_written", 32'hDEAD_BEEF);
        step();
        wb_cp0_reg_we = 1'b0;
        check(epc_o);
        rd("unmapped_read", 5'd3, 32'd0);
        wb_cp0_reg_we = 1'b1;
        wb_cp0_reg_write_addr = 5'd15;
        wb_cp0_reg_data = 32'h1111_2222;
        rd("prid_ro_bypass", 5'd15, 32'h0048_0102);
        step();
        wb_cp0_reg_we = 1'b0;
        rd("prid_ro", 5'd15, 32'h0048_0102);

        wr(5'd9, 32'd1000);
        wr(5'd11, 32'd20);
        push("compare_written", 32'd20); check(compare_o);
        wr(5'd9, 32'd10);
        push("count_written", 32'd10); check(count_o);
        repeat (10) step();
        push("count_at_compare", 32'd20); check(count_o);
        push("timer_before", 32'd0); check({31'd0, timer_int_o});
        step();
        push("timer_rise", TIMER_ON); check({31'd0, timer_int_o});
        repeat (3) step();
        push("timer_hold", TIMER_ON); check({31'd0, timer_int_o});
        wr(5'd11, 32'd100);
        push("timer_clear", 32'd0); check({31'd0, timer_int_o});

        wr(5'd9, 32'hFFFF_FFFF);
        push("count_max", 32'hFFFF_FFFF); check(count_o);
        step();
        push("count_wrap", 32'd0); check(count_o);
        repeat (3) step();

        #2;
        resetn = 1'b0;
        #1;
        push("arst_count", 32'd0); check(count_o);
        push("arst_compare", 32'd0); check(compare_o);
        push("arst_status", 32'h1000_0000); check(status_o);
        push("arst_cause", 32'd0); check(cause_o);
        push("arst_epc", 32'd0); check(epc_o);
        push("arst_timer", 32'd0); check({31'd0, timer_int_o});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
